// File: rtl/mux_scan_ctrl_if.sv
// Select/sample bundle between the scan controller and whoever owns the mux and the request side.
// The controller is the slave: it takes start/mask and the mux output Y, and drives S and the results.
interface mux_scan_ctrl_if;
    logic       start;
    logic [3:0] mask;
    logic [1:0] S;
    logic       Y;
    logic       busy;
    logic       done;
    logic [3:0] snap;
    logic [3:0] chg;

    modport master (output start, mask, Y, input S, busy, done, snap, chg);
    modport slave  (input start, mask, Y, output S, busy, done, snap, chg);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through the enabled channels, dwells DWELL cycles on each,
// samples Y at the end of each dwell, and publishes a snapshot plus change flags.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus_io
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_e     state_q;
    logic [3:0] mask_q;
    logic [7:0] cnt_q;
    logic [1:0] s_q;
    logic [3:0] shadow_q;
    logic [3:0] snap_q;
    logic [3:0] chg_q;
    logic       busy_q;
    logic       done_q;

    logic [1:0] first_ch;
    logic [1:0] next_ch;
    logic       has_next;
    logic [3:0] shadow_d;
    logic [3:0] snap_d;

    // Descending loops so the lowest qualifying channel wins.
    always_comb begin
        first_ch = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus_io.mask[k]) first_ch = 2'(k);
        end
        has_next = 1'b0;
        next_ch  = s_q;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(s_q))) begin
                has_next = 1'b1;
                next_ch  = 2'(k);
            end
        end
        shadow_d      = shadow_q;
        shadow_d[s_q] = bus_io.Y;
        // Only scanned channels take the new sample; the rest keep their old snapshot.
        snap_d = (snap_q & ~mask_q) | (shadow_d & mask_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= 4'd0;
            cnt_q    <= 8'd0;
            s_q      <= 2'd0;
            shadow_q <= 4'd0;
            snap_q   <= 4'd0;
            chg_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.start && (bus_io.mask != 4'd0)) begin
                        mask_q  <= bus_io.mask;
                        cnt_q   <= DWELL_M1;
                        s_q     <= first_ch;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (cnt_q == 8'd0) begin
                        shadow_q <= shadow_d;
                        if (has_next) begin
                            s_q   <= next_ch;
                            cnt_q <= DWELL_M1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            snap_q  <= snap_d;
                            chg_q   <= (snap_d ^ snap_q) & mask_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.S    = s_q;
    assign bus_io.busy = busy_q;
    assign bus_io.done = done_q;
    assign bus_io.snap = snap_q;
    assign bus_io.chg  = chg_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a channel-list model queues the expected select
// sequence and results at each accepted start; a negedge monitor pops and compares.
module tb_mux_scan_ctrl;

    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r = 1'b0;
    logic [3:0] mask_r = 4'd0;
    logic [3:0] in_r = 4'd0;
    bit         fin = 1'b0;

    mux_scan_ctrl_if bus ();

    assign bus.start = start_r;
    assign bus.mask  = mask_r;
    assign bus.Y     = in_r[bus.S];

    mux_scan_ctrl #(.DWELL(DWELL)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard state shared between model (producer) and monitor (consumer).
    int         sq[$];
    logic [7:0] rq[$];
    int         cyc = 0;
    int         free = 0;
    logic [3:0] m_snap = 4'd0;

    int total = 0;
    int bad   = 0;

    // Model: a scan is the list of enabled channels, each repeated DWELL times.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sq.delete();
            rq.delete();
            free   = 0;
            m_snap = 4'd0;
        end else begin
            if (start_r && mask_r != 4'd0 && cyc >= free) begin
                logic [3:0] ns;
                logic [3:0] nc;
                int         n;
                n = 0;
                for (int k = 0; k < 4; k++) begin
                    if (mask_r[k]) begin
                        n++;
                        for (int j = 0; j < DWELL; j++) sq.push_back(k);
                    end
                end
                ns = (m_snap & ~mask_r) | (in_r & mask_r);
                nc = (ns ^ m_snap) & mask_r;
                m_snap = ns;
                rq.push_back({ns, nc});
                free = cyc + n * DWELL + 2;
            end
        end
        if (!rst) cyc++;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        logic [3:0] pub_snap;
        logic [3:0] pub_chg;
        logic [1:0] last_s;
        bit         exp_done;
        bit         done_now;
        logic [7:0] r;
        int         s;
        pub_snap = 0; pub_chg = 0; last_s = 0; exp_done = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (fin) begin
                chk("sq_empty", 8'(sq.size()), 8'd0);
                chk("rq_empty", 8'(rq.size()), 8'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (rst) begin
                #1;
                chk("rst_S", {6'd0, bus.S}, 8'd0);
                chk("rst_busy", {7'd0, bus.busy}, 8'd0);
                chk("rst_done", {7'd0, bus.done}, 8'd0);
                chk("rst_snap", {4'd0, bus.snap}, 8'd0);
                chk("rst_chg", {4'd0, bus.chg}, 8'd0);
                pub_snap = 0; pub_chg = 0; last_s = 0; exp_done = 0;
            end else begin
                done_now = exp_done;
                exp_done = 0;
                if (done_now) begin
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        pub_snap = r[7:4];
                        pub_chg  = r[3:0];
                    end else begin
                        chk("rq_underflow", 8'd1, 8'd0);
                    end
                end
                chk("busy", {7'd0, bus.busy}, {7'd0, sq.size() != 0});
                chk("done", {7'd0, bus.done}, {7'd0, done_now});
                chk("snap", {4'd0, bus.snap}, {4'd0, pub_snap});
                chk("chg", {4'd0, bus.chg}, {4'd0, pub_chg});
                if (sq.size() != 0) begin
                    s = sq.pop_front();
                    chk("S_scan", {6'd0, bus.S}, 8'(s));
                    last_s = 2'(s);
                    if (sq.size() == 0) exp_done = 1;
                end else begin
                    chk("S_hold", {6'd0, bus.S}, {6'd0, last_s});
                end
            end
        end
    end

    // Wait until the model says the controller will accept at the next edge, then request.
    task automatic run(input logic [3:0] i, input logic [3:0] m);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc < free && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_r    = i;
        mask_r  = m;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        mask_r  = 4'($urandom);
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while (cyc < free + 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Start with an empty mask must be ignored.
        start_r = 1'b1; mask_r = 4'd0;
        repeat (3) @(negedge clk);
        start_r = 1'b0;

        run(4'b1010, 4'b1111);
        run(4'b1000, 4'b1001);
        run(4'b0011, 4'b0011);
        settle();

        // Reset mid-cycle during the second channel of a full scan.
        run(4'b0110, 4'b1111);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        start_r = 1'b1; mask_r = 4'd0;
        repeat (3) @(negedge clk);
        start_r = 1'b0;
        run(4'b1010, 4'b1111);
        run(4'b1000, 4'b1001);
        settle();

        // Start held high with the mask changing every cycle.
        in_r = 4'($urandom);
        start_r = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mask_r = 4'($urandom);
            @(negedge clk);
        end
        start_r = 1'b0;
        settle();

        for (int t = 0; t < 40; t++) begin
            run(4'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        settle();
        fin = 1'b1;
    end

endmodule
